datapath: RTL and testbench

Register-transfer datapath of the teaching CPU, sitting directly downstream of the combinational control unit. Each cycle it consumes the unit's one-hot control strobes and 4-bit ALU select, moves data over a single 16-bit internal bus, and updates its architectural registers: AR, PC, DR, TR, IR, R0, R1, X and Z. It drives the memory address/data interface and returns IR and Z to the control unit. It has no instruction knowledge; every transfer is an explicit strobe.

---
 rtl/datapath.sv | 168 ++++++++++++++++
 tb/tb_datapath.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Register-transfer datapath of the teaching CPU: one 16-bit bus,
// an 8-bit ALU and the AR/PC/DR/TR/IR/R0/R1/X/Z registers.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   read .. zload      register/memory strobes from control
//   pcbus .. busmem    bus source/sink enables
//   alus[3:0]          ALU operation select
//   mem_addr[15:0]     memory address (AR)
//   mem_rdata[7:0]     asynchronous memory read data
//   mem_wdata[7:0]     memory write data (bus[7:0])
//   mem_re, mem_we     memory read / write enables
//   ir[7:0], z         IR contents and zero flag back to control
//   pc, r0, r1         debug taps
//   bus_conflict       sticky illegal-bus-drive flag
module datapath (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic        arload,
   input  logic        arinc,
   input  logic        pcinc,
   input  logic        pcload,
   input  logic        drload,
   input  logic        trload,
   input  logic        irload,
   input  logic        r1load,
   input  logic        r0load,
   input  logic        xload,
   input  logic        zload,
   input  logic        pcbus,
   input  logic        drhbus,
   input  logic        drlbus,
   input  logic        trbus,
   input  logic        r1bus,
   input  logic        r0bus,
   input  logic        membus,
   input  logic        busmem,
   input  logic [3:0]  alus,
   output logic [15:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic [7:0]  mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   output logic [7:0]  ir,
   output logic        z,
   output logic [15:0] pc,
   output logic [7:0]  r0,
   output logic [7:0]  r1,
   output logic        bus_conflict
);

   logic [15:0] ar_q, ar_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  dr_q, dr_d;
   logic [7:0]  tr_q, tr_d;
   logic [7:0]  ir_q, ir_d;
   logic [7:0]  r0_q, r0_d;
   logic [7:0]  r1_q, r1_d;
   logic [7:0]  x_q, x_d;
   logic        z_q, z_d;
   logic        bc_q, bc_d;

   logic [15:0] bus;
   logic [7:0]  alu_y;
   logic [2:0]  n_src;
   logic        conflict;

   // Sources are wired-OR; overlapping drivers merge rather than
   // being arbitrated, and the conflict flag records the misuse.
   always_comb begin
      bus = 16'h0000;
      if (pcbus)  bus = bus | pc_q;
      if (drhbus) bus = bus | {dr_q, 8'h00};
      if (drlbus) bus = bus | {8'h00, dr_q};
      if (trbus)  bus = bus | {8'h00, tr_q};
      if (r0bus)  bus = bus | {8'h00, r0_q};
      if (r1bus)  bus = bus | {8'h00, r1_q};
      if (membus) bus = bus | {8'h00, mem_rdata};
   end

   // DR high byte only collides with PC; it may share with any
   // low-byte source (used to assemble 16-bit jump targets).
   always_comb begin
      n_src = {2'b00, pcbus} + {2'b00, drlbus} + {2'b00, trbus}
            + {2'b00, r0bus} + {2'b00, r1bus} + {2'b00, membus};
      conflict = (n_src > 3'd1) | (pcbus & drhbus);
   end

   always_comb begin
      alu_y = 8'h00;
      case (alus)
         4'b0001: alu_y = x_q + bus[7:0];
         4'b0010: alu_y = x_q - bus[7:0];
         4'b0011: alu_y = x_q + 8'd1;
         4'b0100: alu_y = x_q - 8'd1;
         4'b0101: alu_y = x_q & bus[7:0];
         4'b0110: alu_y = x_q | bus[7:0];
         4'b0111: alu_y = ~x_q;
         4'b1000: alu_y = x_q ^ bus[7:0];
         4'b1001: alu_y = {x_q[6:0], 1'b0};
         default: alu_y = 8'h00;
      endcase
   end

   always_comb begin
      ar_d = ar_q;
      pc_d = pc_q;
      dr_d = dr_q;
      tr_d = tr_q;
      ir_d = ir_q;
      r0_d = r0_q;
      r1_d = r1_q;
      x_d  = x_q;
      z_d  = z_q;
      bc_d = bc_q | conflict;
      if (arload)     ar_d = bus;
      else if (arinc) ar_d = ar_q + 16'd1;
      if (pcload)     pc_d = bus;
      else if (pcinc) pc_d = pc_q + 16'd1;
      if (drload) dr_d = bus[7:0];
      if (trload) tr_d = dr_q;
      if (irload) ir_d = dr_q;
      if (xload)  x_d  = bus[7:0];
      if (r1load) r1_d = bus[7:0];
      if (r0load) r0_d = alu_y;
      if (zload)  z_d  = (alu_y == 8'h00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ar_q <= 16'h0000;
         pc_q <= 16'h0000;
         dr_q <= 8'h00;
         tr_q <= 8'h00;
         ir_q <= 8'h00;
         r0_q <= 8'h00;
         r1_q <= 8'h00;
         x_q  <= 8'h00;
         z_q  <= 1'b0;
         bc_q <= 1'b0;
      end else begin
         ar_q <= ar_d;
         pc_q <= pc_d;
         dr_q <= dr_d;
         tr_q <= tr_d;
         ir_q <= ir_d;
         r0_q <= r0_d;
         r1_q <= r1_d;
         x_q  <= x_d;
         z_q  <= z_d;
         bc_q <= bc_d;
      end
   end

   assign mem_addr     = ar_q;
   assign mem_wdata    = bus[7:0];
   assign mem_re       = read;
   assign mem_we       = write & busmem;
   assign ir           = ir_q;
   assign z            = z_q;
   assign pc           = pc_q;
   assign r0           = r0_q;
   assign r1           = r1_q;
   assign bus_conflict = bc_q;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath: fetch, ALU, jump,
// wrap/priority, bus conflict and reset-mid-op sequences.
module tb_datapath;

   logic clk = 1'b0;
   logic rst;
   logic read, write, arload, arinc, pcinc, pcload;
   logic drload, trload, irload, r1load, r0load, xload, zload;
   logic pcbus, drhbus, drlbus, trbus, r1bus, r0bus, membus, busmem;
   logic [3:0]  alus;
   logic [15:0] mem_addr;
   logic [7:0]  mem_rdata, mem_wdata;
   logic        mem_re, mem_we;
   logic [7:0]  ir, r0, r1;
   logic        z, bus_conflict;
   logic [15:0] pc;

   logic [7:0] mem [0:255];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:0]];

   always @(posedge clk)
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

   datapath dut (
      .clk(clk), .rst(rst), .read(read), .write(write),
      .arload(arload), .arinc(arinc), .pcinc(pcinc),
      .pcload(pcload), .drload(drload), .trload(trload),
      .irload(irload), .r1load(r1load), .r0load(r0load),
      .xload(xload), .zload(zload), .pcbus(pcbus),
      .drhbus(drhbus), .drlbus(drlbus), .trbus(trbus),
      .r1bus(r1bus), .r0bus(r0bus), .membus(membus),
      .busmem(busmem), .alus(alus), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
      .mem_re(mem_re), .mem_we(mem_we), .ir(ir), .z(z),
      .pc(pc), .r0(r0), .r1(r1), .bus_conflict(bus_conflict)
   );

   task automatic chk(input string tag,
                      input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic idle();
      rst = 0; read = 0; write = 0; arload = 0; arinc = 0;
      pcinc = 0; pcload = 0; drload = 0; trload = 0;
      irload = 0; r1load = 0; r0load = 0; xload = 0;
      zload = 0; pcbus = 0; drhbus = 0; drlbus = 0;
      trbus = 0; r1bus = 0; r0bus = 0; membus = 0;
      busmem = 0; alus = 4'b0000;
   endtask

   // One clock edge, then settle; strobes are cleared afterwards.
   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   logic [3:0] op_v  [10] = '{4'b0010, 4'b0101, 4'b1000, 4'b1001,
                              4'b0111, 4'b0011, 4'b0100, 4'b0000,
                              4'b1111, 4'b1010};
   logic [7:0] res_v [10] = '{8'h0B, 8'h00, 8'hFF, 8'h0A,
                              8'hFA, 8'h06, 8'h04, 8'h00,
                              8'h00, 8'h00};

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h10; mem[8'h01] = 8'h20; mem[8'h02] = 8'hAA;
      mem[8'h10] = 8'h34; mem[8'h11] = 8'h12; mem[8'h12] = 8'hFF;
      mem[8'h20] = 8'h05; mem[8'h21] = 8'hFB; mem[8'h22] = 8'hFA;
      mem[8'h23] = 8'h10; mem[8'h30] = 8'h0F; mem[8'h31] = 8'hF0;
      mem[8'h32] = 8'h55; mem[8'hAA] = 8'h30;

      idle();
      rst = 1;
      cyc();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_ar", mem_addr, 16'h0000);
      chk("rst_r0", {8'h00, r0}, 16'h0000);
      chk("rst_ir", {8'h00, ir}, 16'h0000);
      chk("rst_z", {15'h0, z}, 16'h0000);
      chk("rst_bc", {15'h0, bus_conflict}, 16'h0000);

      // Fetch
      pcbus = 1; arload = 1; cyc();
      chk("f1_ar", mem_addr, 16'h0000);
      read = 1; membus = 1; drload = 1; pcinc = 1;
      #1 chk("f2_re", {15'h0, mem_re}, 16'h0001);
      cyc();
      chk("f2_pc", pc, 16'h0001);
      drlbus = 1;
      #1 chk("f2_dr", {8'h00, mem_wdata}, 16'h0010);
      idle();
      pcbus = 1; arload = 1; irload = 1; cyc();
      chk("f3_ir", {8'h00, ir}, 16'h0010);
      chk("f3_ar", mem_addr, 16'h0001);

      // ADD to zero
      membus = 1; arload = 1; cyc();
      chk("ar20", mem_addr, 16'h0020);
      membus = 1; xload = 1; arinc = 1; cyc();
      r0load = 1; alus = 4'b0110; cyc();
      chk("r0_05", {8'h00, r0}, 16'h0005);
      membus = 1; r1load = 1; arinc = 1; cyc();
      chk("r1_fb", {8'h00, r1}, 16'h00FB);
      r0bus = 1; xload = 1; cyc();
      r1bus = 1; r0load = 1; zload = 1; alus = 4'b0001; cyc();
      chk("add0_r0", {8'h00, r0}, 16'h0000);
      chk("add0_z", {15'h0, z}, 16'h0001);
      membus = 1; r1load = 1; arinc = 1; cyc();
      r1bus = 1; r0load = 1; zload = 1; alus = 4'b0001; cyc();
      chk("addff_r0", {8'h00, r0}, 16'h00FF);
      chk("addff_z", {15'h0, z}, 16'h0000);

      // Remaining ALU ops, X=05, B=R1=FA
      for (int i = 0; i < 10; i++) begin
         r1bus = 1; r0load = 1; zload = 1; alus = op_v[i]; cyc();
         chk($sformatf("alu%b_r0", op_v[i]), {8'h00, r0},
             {8'h00, res_v[i]});
         chk($sformatf("alu%b_z", op_v[i]), {15'h0, z},
             {15'h0, res_v[i] == 8'h00});
      end

      // Jump
      membus = 1; arload = 1; cyc();
      chk("ar10", mem_addr, 16'h0010);
      read = 1; membus = 1; drload = 1; arinc = 1; cyc();
      chk("j1_ar", mem_addr, 16'h0011);
      read = 1; membus = 1; drload = 1; trload = 1; cyc();
      trbus = 1;
      #1 chk("j2_tr", {8'h00, mem_wdata}, 16'h0034);
      idle(); drlbus = 1;
      #1 chk("j2_dr", {8'h00, mem_wdata}, 16'h0012);
      idle();
      drhbus = 1; trbus = 1; pcload = 1; cyc();
      chk("j3_pc", pc, 16'h1234);
      chk("j3_bc", {15'h0, bus_conflict}, 16'h0000);

      // Wrap and load-over-increment priority
      arinc = 1; cyc();
      membus = 1; drload = 1; cyc();
      drhbus = 1; drlbus = 1; pcload = 1; arload = 1; cyc();
      chk("pc_ffff", pc, 16'hFFFF);
      chk("ar_ffff", mem_addr, 16'hFFFF);
      chk("dd_bc", {15'h0, bus_conflict}, 16'h0000);
      pcinc = 1; arinc = 1; cyc();
      chk("pc_wrap", pc, 16'h0000);
      chk("ar_wrap", mem_addr, 16'h0000);
      arinc = 1; cyc();
      arinc = 1; cyc();
      membus = 1; pcinc = 1; pcload = 1; arload = 1; arinc = 1;
      cyc();
      chk("pc_prio", pc, 16'h00AA);
      chk("ar_prio", mem_addr, 16'h00AA);

      // Memory write enable gating
      r1bus = 1; write = 1; busmem = 1;
      #1 chk("we_on", {15'h0, mem_we}, 16'h0001);
      chk("wdata", {8'h00, mem_wdata}, 16'h00FA);
      busmem = 0;
      #1 chk("we_off", {15'h0, mem_we}, 16'h0000);
      idle();

      // Conflict
      membus = 1; arload = 1; cyc();
      membus = 1; xload = 1; arinc = 1; cyc();
      r0load = 1; alus = 4'b0110; cyc();
      membus = 1; r1load = 1; arinc = 1; cyc();
      chk("c_r0", {8'h00, r0}, 16'h000F);
      chk("c_r1", {8'h00, r1}, 16'h00F0);
      r0bus = 1; r1bus = 1; xload = 1;
      #1 chk("c_pre", {15'h0, bus_conflict}, 16'h0000);
      cyc();
      chk("c_set", {15'h0, bus_conflict}, 16'h0001);
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk($sformatf("c_hold%0d", i), {15'h0, bus_conflict},
             16'h0001);
      end
      r0load = 1; alus = 4'b0110; cyc();
      chk("c_x", {8'h00, r0}, 16'h00FF);

      // Reset mid-op
      membus = 1; xload = 1; cyc();
      rst = 1; r0load = 1; zload = 1; alus = 4'b0011;
      pcinc = 1; arinc = 1; cyc();
      chk("rm_r0", {8'h00, r0}, 16'h0000);
      chk("rm_r1", {8'h00, r1}, 16'h0000);
      chk("rm_pc", pc, 16'h0000);
      chk("rm_ar", mem_addr, 16'h0000);
      chk("rm_z", {15'h0, z}, 16'h0000);
      chk("rm_bc", {15'h0, bus_conflict}, 16'h0000);
      r0load = 1; zload = 1; alus = 4'b0110; cyc();
      chk("rm_x", {8'h00, r0}, 16'h0000);
      chk("rm_xz", {15'h0, z}, 16'h0001);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
